// File: rtl/parse_poly_buf.sv
// parse_poly_buf: double-buffered polynomial store between the rejection
// sampler and the NTT-domain consumers. Beats of NC coefficients fill one
// bank while the other bank is served through a registered random-access
// read port. Coefficient range, stream length and overflow are reported
// through sticky flags.
module parse_poly_buf #(
    parameter int Q  = 3329,
    parameter int CW = 12,
    parameter int NC = 4,
    parameter int N  = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NC*CW-1:0]     i_coeffs,
    input  logic                 i_coeffs_valid,
    input  logic                 i_done,
    output logic                 o_in_ready,
    output logic                 o_poly_valid,
    input  logic                 i_rd_en,
    input  logic [$clog2(N)-1:0] i_rd_addr,
    output logic [CW-1:0]        o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_rel,
    output logic                 o_wr_bank,
    output logic                 o_rd_bank,
    output logic                 o_err_range,
    output logic                 o_err_len,
    output logic                 o_ovf
);

    localparam int NB = N / NC;          // beats per polynomial
    localparam int BW = $clog2(NB);      // beat counter / word address width
    localparam int LW = $clog2(NC);      // lane index width
    localparam int WW = NC * CW;         // storage word width
    localparam logic [CW-1:0] Q_C   = CW'(Q);
    localparam logic [BW-1:0] LAST  = BW'(NB - 1);

    // Bank b occupies words {b, beat}; lane 0 sits in the top CW bits.
    logic [WW-1:0] mem_q [0:2*NB-1];

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_range_q, err_range_d;
    logic          err_len_q, err_len_d;
    logic          ovf_q, ovf_d;

    logic          in_ready;
    logic          poly_valid;
    logic          accept;
    logic          last_beat;
    logic          range_hit;
    logic          rd_fire;
    logic          rel_fire;
    logic [WW-1:0] rd_word;
    logic [CW-1:0] rd_lane;
    logic [BW:0]   wr_addr;

    assign in_ready   = ~full_q[wr_bank_q];
    assign poly_valid = full_q[rd_bank_q];
    assign accept     = i_coeffs_valid & in_ready;
    assign last_beat  = accept & (bcnt_q == LAST);
    assign rd_fire    = i_rd_en & poly_valid;
    assign rel_fire   = i_rel & poly_valid;
    assign wr_addr    = {wr_bank_q, bcnt_q};
    assign rd_word    = mem_q[{rd_bank_q, i_rd_addr[$clog2(N)-1:LW]}];

    // Flag any lane of the incoming beat that is not a valid residue mod Q.
    always_comb begin
        range_hit = 1'b0;
        for (int l = 0; l < NC; l++) begin
            if (i_coeffs[l*CW +: CW] >= Q_C) begin
                range_hit = 1'b1;
            end
        end
    end

    // Select the addressed coefficient out of the read-bank word.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        rd_lane = '0;
        for (int l = 0; l < NC; l++) begin
            if (i_rd_addr[LW-1:0] == LW'(l)) begin
                rd_lane = rd_word[(NC-1-l)*CW +: CW];
            end
        end
    end

    // Next-state logic for bank pointers, beat counter, read port and flags.
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bcnt_d      = bcnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_fire;
        err_range_d = err_range_q | (accept & range_hit);
        err_len_d   = err_len_q;
        ovf_d       = ovf_q | (i_coeffs_valid & ~in_ready);

        if (accept) begin
            if (last_beat) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                bcnt_d            = '0;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        // A done pulse mid-polynomial abandons the partial fill; the bank
        // stays not-full and the next beat restarts at word 0.
        if (i_done && (bcnt_q != '0) && !last_beat) begin
            err_len_d = 1'b1;
            bcnt_d    = '0;
        end

        // A completing write can only target the empty bank, while a release
        // needs the read bank full, so the two never touch the same bit.
        if (rel_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        // The read is taken from the current read bank even if it is being
        // released in this same cycle.
        if (rd_fire) begin
            rd_data_d = rd_lane;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bcnt_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_range_q <= 1'b0;
            err_len_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bcnt_q      <= bcnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_range_q <= err_range_d;
            err_len_q   <= err_len_d;
            ovf_q       <= ovf_d;
        end
    end

    // Coefficient storage: write the accepted beat into the fill bank.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is deliberately not reset; clearing the
        // full bits is enough to discard its contents, and a reset-free
        // array maps onto RAM.
        if (accept) begin
            mem_q[wr_addr] <= i_coeffs;
        end
    end

    assign o_in_ready   = in_ready;
    assign o_poly_valid = poly_valid;
    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_wr_bank    = wr_bank_q;
    assign o_rd_bank    = rd_bank_q;
    assign o_err_range  = err_range_q;
    assign o_err_len    = err_len_q;
    assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_parse_poly_buf.sv
// Directed testbench for parse_poly_buf. Inputs are driven and outputs are
// sampled on the falling clock edge; all expected values are computed here.
module tb_parse_poly_buf;

    localparam int Q  = 3329;
    localparam int CW = 12;
    localparam int NC = 4;
    localparam int N  = 256;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NC*CW-1:0]  i_coeffs;
    logic              i_coeffs_valid;
    logic              i_done;
    logic              o_in_ready;
    logic              o_poly_valid;
    logic              i_rd_en;
    logic [7:0]        i_rd_addr;
    logic [CW-1:0]     o_rd_data;
    logic              o_rd_valid;
    logic              i_rel;
    logic              o_wr_bank;
    logic              o_rd_bank;
    logic              o_err_range;
    logic              o_err_len;
    logic              o_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    parse_poly_buf #(.Q(Q), .CW(CW), .NC(NC), .N(N)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .i_done         (i_done),
        .o_in_ready     (o_in_ready),
        .o_poly_valid   (o_poly_valid),
        .i_rd_en        (i_rd_en),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rel          (i_rel),
        .o_wr_bank      (o_wr_bank),
        .o_rd_bank      (o_rd_bank),
        .o_err_range    (o_err_range),
        .o_err_len      (o_err_len),
        .o_ovf          (o_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Coefficient i of a test polynomial is (base + i) mod Q.
    function automatic logic [CW-1:0] coef(input int base, input int i);
        return CW'((base + i) % Q);
    endfunction

    function automatic logic [NC*CW-1:0] beat_word(input int base, input int k);
        logic [NC*CW-1:0] w;
        for (int l = 0; l < NC; l++) begin
            w[(NC-1-l)*CW +: CW] = coef(base, NC*k + l);
        end
        return w;
    endfunction

    task automatic idle();
        i_coeffs_valid = 1'b0;
        i_done         = 1'b0;
        i_rel          = 1'b0;
        i_rd_en        = 1'b0;
    endtask

    // Back-to-back beats first..first+count-1; optional done on the last one.
    task automatic send_beats(input int base, input int first, input int count, input bit done_last);
        for (int k = 0; k < count; k++) begin
            i_coeffs       = beat_word(base, first + k);
            i_coeffs_valid = 1'b1;
            i_done         = done_last && (k == count - 1);
            @(negedge i_clk);
        end
        i_coeffs_valid = 1'b0;
        i_done         = 1'b0;
    endtask

    // Back-to-back reads, checking valid and data one cycle after each request.
    task automatic read_range(input string tag, input int base, input int start, input int count);
        for (int a = start; a < start + count; a++) begin
            i_rd_en   = 1'b1;
            i_rd_addr = 8'(a);
            @(negedge i_clk);
            check(tag, {19'd0, o_rd_valid, o_rd_data}, {19'd0, 1'b1, coef(base, a)});
        end
        i_rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(o_in_ready), 32'd1);
        check({tag, "_pvalid"}, 32'(o_poly_valid), 32'd0);
        check({tag, "_banks"}, {30'd0, o_wr_bank, o_rd_bank}, 32'd0);
        check({tag, "_rd"}, {19'd0, o_rd_valid, o_rd_data}, 32'd0);
        check({tag, "_flags"}, {29'd0, o_err_range, o_err_len, o_ovf}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst     = 1'b1;
        i_coeffs  = '0;
        i_rd_addr = '0;
        idle();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_state("reset");

        // Two polynomials back to back, with no gap at the bank switch.
        send_beats(0, 0, NC*0 + 64, 1'b1);
        check("p1_pvalid", 32'(o_poly_valid), 32'd1);
        check("p1_wr_bank", 32'(o_wr_bank), 32'd1);
        check("p1_ready", 32'(o_in_ready), 32'd1);
        send_beats(1000, 0, 64, 1'b1);
        check("p2_ready", 32'(o_in_ready), 32'd0);
        check("p2_wr_bank", 32'(o_wr_bank), 32'd0);
        check("p2_rd_bank", 32'(o_rd_bank), 32'd0);
        read_range("p1_read", 0, 0, 256);
        @(negedge i_clk);
        check("p1_rd_valid_low", 32'(o_rd_valid), 32'd0);
        check("p1_flags", {29'd0, o_err_range, o_err_len, o_ovf}, 32'd0);

        // Third polynomial finds both banks full: its beat is dropped.
        i_coeffs       = beat_word(2000, 0);
        i_coeffs_valid = 1'b1;
        @(negedge i_clk);
        i_coeffs_valid = 1'b0;
        check("ovf_flag", 32'(o_ovf), 32'd1);

        // Release with a read in the same cycle: data comes from the old bank.
        i_rel     = 1'b1;
        i_rd_en   = 1'b1;
        i_rd_addr = 8'd2;
        @(negedge i_clk);
        idle();
        check("rel_read_old", {19'd0, o_rd_valid, o_rd_data}, {19'd0, 1'b1, coef(0, 2)});
        check("rel_rd_bank", 32'(o_rd_bank), 32'd1);
        check("rel_pvalid", 32'(o_poly_valid), 32'd1);
        check("rel_ready", 32'(o_in_ready), 32'd1);
        read_range("p2_read_lo", 1000, 0, 8);
        read_range("p2_read_hi", 1000, 248, 8);

        // Release coincident with the completing beat of the other bank.
        send_beats(2000, 0, 63, 1'b0);
        i_coeffs       = beat_word(2000, 63);
        i_coeffs_valid = 1'b1;
        i_done         = 1'b1;
        i_rel          = 1'b1;
        i_rd_en        = 1'b1;
        i_rd_addr      = 8'd3;
        @(negedge i_clk);
        idle();
        check("conc_read_old", {19'd0, o_rd_valid, o_rd_data}, {19'd0, 1'b1, coef(1000, 3)});
        check("conc_banks", {30'd0, o_wr_bank, o_rd_bank}, 32'b10);
        check("conc_pvalid", 32'(o_poly_valid), 32'd1);
        check("conc_ready", 32'(o_in_ready), 32'd1);
        check("conc_len_ok", 32'(o_err_len), 32'd0);
        read_range("p4_read_lo", 2000, 0, 4);
        read_range("p4_read_hi", 2000, 252, 4);

        // Range check: 0xD00 is the largest legal value, 0xD01 and 0xFFF are not.
        i_coeffs       = 48'h000_000_000_D00;
        i_coeffs_valid = 1'b1;
        @(negedge i_clk);
        check("range_d00_ok", 32'(o_err_range), 32'd0);
        i_coeffs = 48'hD01_000_FFF_D00;
        @(negedge i_clk);
        i_coeffs_valid = 1'b0;
        check("range_flag", 32'(o_err_range), 32'd1);

        // Length check: done after 10 beats abandons the partial polynomial.
        send_beats(500, 2, 8, 1'b0);
        check("len_before", 32'(o_err_len), 32'd0);
        i_done = 1'b1;
        @(negedge i_clk);
        i_done = 1'b0;
        check("len_flag", 32'(o_err_len), 32'd1);
        check("len_wr_bank", 32'(o_wr_bank), 32'd1);
        send_beats(3000, 0, 63, 1'b0);
        check("len_63_wr_bank", 32'(o_wr_bank), 32'd1);
        check("len_63_ready", 32'(o_in_ready), 32'd1);
        send_beats(3000, 63, 1, 1'b1);
        check("len_64_wr_bank", 32'(o_wr_bank), 32'd0);
        check("len_64_ready", 32'(o_in_ready), 32'd0);
        i_rel = 1'b1;
        @(negedge i_clk);
        i_rel = 1'b0;
        check("p5_rd_bank", 32'(o_rd_bank), 32'd1);
        read_range("p5_read_lo", 3000, 0, 4);
        read_range("p5_read_mid", 3000, 36, 4);
        read_range("p5_read_hi", 3000, 252, 4);

        // With nothing to read, reads and releases are ignored.
        i_rel = 1'b1;
        @(negedge i_clk);
        check("empty_rd_bank", 32'(o_rd_bank), 32'd0);
        check("empty_pvalid", 32'(o_poly_valid), 32'd0);
        check("empty_ready", 32'(o_in_ready), 32'd1);
        i_rd_en   = 1'b1;
        i_rd_addr = 8'd9;
        @(negedge i_clk);
        idle();
        check("empty_read", {19'd0, o_rd_valid, o_rd_data}, {19'd0, 1'b0, coef(3000, 255)});
        check("empty_rel_ignored", 32'(o_rd_bank), 32'd0);
        check("sticky_flags", {29'd0, o_err_range, o_err_len, o_ovf}, 32'b111);

        // Reset in the middle of a fill, then a fresh polynomial into bank 0.
        send_beats(500, 0, 30, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_reset_state("midfill_reset");
        send_beats(100, 0, 64, 1'b1);
        check("fresh_pvalid", 32'(o_poly_valid), 32'd1);
        check("fresh_banks", {30'd0, o_wr_bank, o_rd_bank}, 32'b10);
        read_range("fresh_read_lo", 100, 0, 4);
        read_range("fresh_read_mid", 100, 120, 4);
        read_range("fresh_read_hi", 100, 252, 4);
        check("fresh_flags", {29'd0, o_err_range, o_err_len, o_ovf}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
